// File: rtl/ap_fifo_stream_arbiter_if.sv
// Stream bundle between the HLS kernel sources, the arbiter and fifo_from_function.
// The master modport is the arbiter's view; slave is the kernels/shell side.
interface ap_fifo_stream_arbiter_if #(
    parameter int unsigned NSRC = 4,
    parameter int unsigned DW   = 128
);
    logic [NSRC-1:0]    src_req;
    logic [NSRC*DW-1:0] src_din;
    logic [NSRC-1:0]    src_write;
    logic [NSRC-1:0]    src_full;
    logic [DW-1:0]      out_r_din;
    logic               out_r_write;
    logic               out_r_full;

    modport master (
        input  src_req, src_din, src_write, out_r_full,
        output src_full, out_r_din, out_r_write
    );

    modport slave (
        output src_req, src_din, src_write, out_r_full,
        input  src_full, out_r_din, out_r_write
    );
endinterface

// File: rtl/ap_fifo_stream_arbiter.sv
// Round-robin packet arbiter sharing one ap_fifo write port among NSRC kernel
// streams. Each packet is prefixed by a header beat (magic 8'hA5, source id,
// packet number, length) so the host can demultiplex the merged stream.
module ap_fifo_stream_arbiter #(
    parameter int unsigned NSRC  = 4,
    parameter int unsigned ID_W  = 2,
    parameter int unsigned DW    = 128,
    parameter int unsigned LEN_W = 16
) (
    input  logic                      ip_clk,
    input  logic                      ip_rst,
    input  logic                      cfg_enable,
    input  logic [LEN_W-1:0]          cfg_pkt_len,
    ap_fifo_stream_arbiter_if.master  bus,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    output logic [31:0]               pkt_count,
    output logic                      err_bad_write
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   beat_q, beat_d;
    logic [31:0]        pkt_q, pkt_d;
    logic               err_q, err_d;

    logic               found;
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    cand;
    logic [NSRC-1:0]    gmask;
    logic [NSRC-1:0]    legal_wr;
    logic               accept;
    logic [DW-1:0]      src_word [NSRC];
    logic [DW-1:0]      out_din_c;
    logic               out_wr_c;
    logic [NSRC-1:0]    src_full_c;

    // Split the flat source data bus into one word per source.
    always_comb begin
        for (int unsigned i = 0; i < NSRC; i++) begin
            src_word[i] = bus.src_din[DW*i +: DW];
        end
    end

    // Round-robin search: first requester after the last winner, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned off = 1; off <= NSRC; off++) begin
            cand = ID_W'((32'(rr_q) + off) % NSRC);
            if (!found && bus.src_req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // One-hot mask of the granted source; only it may write, and only in DATA.
    always_comb begin
        gmask           = '0;
        gmask[grant_q]  = 1'b1;
        legal_wr        = (state_q == ST_DATA) ? gmask : '0;
    end

    // Next-state, counters and the combinational output mux.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        len_d      = len_q;
        beat_d     = beat_q;
        pkt_d      = pkt_q;
        err_d      = err_q | (|(bus.src_write & ~legal_wr));
        out_din_c  = '0;
        out_wr_c   = 1'b0;
        src_full_c = '1;
        accept     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_enable && found) begin
                    grant_d = winner;
                    rr_d    = winner;
                    len_d   = cfg_pkt_len;
                    beat_d  = '0;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                out_din_c = {8'hA5, 8'(grant_q), 16'h0, pkt_q, 32'h0, 16'h0, 16'(len_q)};
                out_wr_c  = !bus.out_r_full;
                if (!bus.out_r_full) begin
                    pkt_d   = pkt_q + 32'd1;
                    state_d = (len_q == '0) ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                out_din_c           = src_word[grant_q];
                src_full_c[grant_q] = bus.out_r_full;
                accept              = bus.src_write[grant_q] & !bus.out_r_full;
                out_wr_c            = accept;
                if (accept) begin
                    beat_d = beat_q + LEN_W'(1);
                    if (beat_q + LEN_W'(1) == len_q) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, grant and counter registers.
    always_ff @(posedge ip_clk or posedge ip_rst) begin
        if (ip_rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            rr_q    <= ID_W'(NSRC - 1);
            len_q   <= '0;
            beat_q  <= '0;
            pkt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            pkt_q   <= pkt_d;
            err_q   <= err_d;
        end
    end

    assign bus.out_r_din   = out_din_c;
    assign bus.out_r_write = out_wr_c;
    assign bus.src_full    = src_full_c;
    assign grant_id        = grant_q;
    assign busy            = (state_q != ST_IDLE);
    assign pkt_count       = pkt_q;
    assign err_bad_write   = err_q;

endmodule

// File: tb/tb_ap_fifo_stream_arbiter.sv
// Directed/randomised bench for ap_fifo_stream_arbiter. A packet-level model
// predicts round-robin winners and the exact merged output word stream.
module tb_ap_fifo_stream_arbiter;
    localparam int NSRC = 4;
    localparam int DW   = 128;

    logic        ip_clk;
    logic        ip_rst;
    logic        cfg_enable;
    logic [15:0] cfg_pkt_len;
    logic [1:0]  grant_id;
    logic        busy;
    logic [31:0] pkt_count;
    logic        err_bad_write;

    ap_fifo_stream_arbiter_if #(.NSRC(NSRC), .DW(DW)) bus ();

    ap_fifo_stream_arbiter #(.NSRC(NSRC), .ID_W(2), .DW(DW), .LEN_W(16)) dut (
        .ip_clk        (ip_clk),
        .ip_rst        (ip_rst),
        .cfg_enable    (cfg_enable),
        .cfg_pkt_len   (cfg_pkt_len),
        .bus           (bus),
        .grant_id      (grant_id),
        .busy          (busy),
        .pkt_count     (pkt_count),
        .err_bad_write (err_bad_write)
    );

    int           n_assert = 0;
    int           n_fail   = 0;
    int           m_rr     = NSRC - 1;
    logic [31:0]  m_pkt    = 0;
    logic [127:0] exp_q[$];
    logic [127:0] got_q[$];

    initial ip_clk = 1'b0;
    always #5 ip_clk = ~ip_clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ip_clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] hdr(input int g, input logic [31:0] p, input int n);
        return {8'hA5, 8'(g), 16'h0, p, 32'h0, 16'h0, 16'(n)};
    endfunction

    // First requester after the model's last winner, wrapping modulo NSRC.
    function automatic int rr_pick(input logic [3:0] req);
        for (int k = 1; k <= NSRC; k++) begin
            if (req[(m_rr + k) % NSRC]) return (m_rr + k) % NSRC;
        end
        return -1;
    endfunction

    // Every accepted write into fifo_from_function is captured here.
    always @(negedge ip_clk) begin
        if (bus.out_r_write === 1'b1) begin
            got_q.push_back(bus.out_r_din);
            chk("write_while_full", 128'(bus.out_r_full), 128'(0));
        end
    end

    task automatic compare_streams(input string tag);
        int n;
        chk({tag, "_len"}, 128'(got_q.size()), 128'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk(tag, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_busy();
        int budget = 0;
        while (busy !== 1'b1 && budget < 40) begin
            tick();
            budget++;
        end
        chk("grant_wait", 128'(busy), 128'(1));
    endtask

    // Act as source g for one packet of n beats, with optional stalls and an
    // intruding write from another source on the first data beat.
    task automatic do_packet(input int g, input int n, input int hdr_stall,
                             input int stall_beat, input int stall_len,
                             input int intruder, input bit clear_req, input bit drop_en);
        logic [127:0] d;
        wait_busy();
        chk("grant_id", 128'(grant_id), 128'(g));
        exp_q.push_back(hdr(g, m_pkt, n));
        m_pkt++;
        m_rr = g;
        if (clear_req) bus.src_req = '0;
        if (drop_en) cfg_enable = 1'b0;
        cfg_pkt_len = 16'($urandom);
        #1;
        chk("hdr_src_full", 128'(bus.src_full), 128'(4'hF));
        bus.out_r_full = (hdr_stall > 0);
        repeat (hdr_stall) tick();
        bus.out_r_full = 1'b0;
        tick();
        for (int b = 0; b < n; b++) begin
            d = rand128();
            bus.src_din[DW*g +: DW] = d;
            bus.src_write[g] = 1'b1;
            exp_q.push_back(d);
            if (intruder >= 0 && b == 0) begin
                bus.src_din[DW*intruder +: DW] = rand128();
                bus.src_write[intruder] = 1'b1;
            end
            if (b == stall_beat) begin
                bus.out_r_full = 1'b1;
                repeat (stall_len) tick();
                bus.out_r_full = 1'b0;
            end
            tick();
            if (intruder >= 0) bus.src_write[intruder] = 1'b0;
        end
        bus.src_write = '0;
        #1;
        chk("pkt_end_idle", 128'(busy), 128'(0));
        chk("pkt_count", 128'(pkt_count), 128'(m_pkt));
        compare_streams("stream");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int           g;
        int           n;
        logic [3:0]   mask;
        logic [127:0] d;

        ip_rst         = 1'b1;
        cfg_enable     = 1'b1;
        cfg_pkt_len    = 16'd0;
        bus.src_req    = '0;
        bus.src_din    = '0;
        bus.src_write  = '0;
        bus.out_r_full = 1'b0;
        repeat (3) tick();
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_src_full", 128'(bus.src_full), 128'(4'hF));
        chk("rst_out_write", 128'(bus.out_r_write), 128'(0));
        chk("rst_out_din", bus.out_r_din, 128'(0));
        chk("rst_grant", 128'(grant_id), 128'(0));
        chk("rst_pkt_count", 128'(pkt_count), 128'(0));
        chk("rst_err", 128'(err_bad_write), 128'(0));
        ip_rst = 1'b0;
        tick();

        // Round robin with all sources requesting, len=1: order 0,1,2,3,0.
        bus.src_req = 4'b1111;
        for (int p = 0; p < 5; p++) begin
            cfg_pkt_len = 16'd1;
            g = rr_pick(4'b1111);
            chk("rr_model_order", 128'(g), 128'(p % NSRC));
            do_packet(g, 1, 0, -1, 0, -1, (p == 4), 1'b0);
        end

        // Single source, len=3, request dropped mid-packet.
        cfg_pkt_len = 16'd3;
        bus.src_req = 4'b0001;
        do_packet(rr_pick(4'b0001), 3, 0, -1, 0, -1, 1'b1, 1'b0);

        // Backpressure: 5 stalled header cycles, 3 stalled cycles on beat 2 of 4.
        cfg_pkt_len = 16'd4;
        bus.src_req = 4'b0010;
        do_packet(rr_pick(4'b0010), 4, 5, 1, 3, -1, 1'b1, 1'b0);

        // Header-only packet.
        cfg_pkt_len = 16'd0;
        bus.src_req = 4'b1000;
        do_packet(rr_pick(4'b1000), 0, 0, -1, 0, -1, 1'b1, 1'b0);

        // Enable dropped mid-packet: packet completes, no new grant afterwards.
        cfg_pkt_len = 16'd4;
        bus.src_req = 4'b0001;
        do_packet(rr_pick(4'b0001), 4, 0, -1, 0, -1, 1'b0, 1'b1);
        repeat (5) tick();
        chk("disabled_idle", 128'(busy), 128'(0));
        chk("disabled_pkt_count", 128'(pkt_count), 128'(m_pkt));
        bus.src_req = '0;
        cfg_enable  = 1'b1;
        tick();

        // Randomised packets over random request masks.
        for (int p = 0; p < 8; p++) begin
            mask = 4'($urandom_range(1, 15));
            n    = $urandom_range(1, 5);
            g    = rr_pick(mask);
            cfg_pkt_len = 16'(n);
            bus.src_req = mask;
            do_packet(g, n, $urandom_range(0, 2), $urandom_range(0, n - 1),
                      $urandom_range(0, 2), -1, 1'b1, 1'b0);
        end
        chk("err_clear_before", 128'(err_bad_write), 128'(0));

        // Source 2 writes while source 0 holds the grant.
        cfg_pkt_len = 16'd3;
        bus.src_req = 4'b0001;
        do_packet(rr_pick(4'b0001), 3, 0, -1, 0, 2, 1'b1, 1'b0);
        chk("err_set", 128'(err_bad_write), 128'(1));

        // Reset mid-DATA on a source-2 packet.
        cfg_pkt_len = 16'd4;
        bus.src_req = 4'b0100;
        g = rr_pick(4'b0100);
        wait_busy();
        chk("rst_pkt_grant", 128'(grant_id), 128'(g));
        exp_q.push_back(hdr(g, m_pkt, 4));
        bus.src_req = '0;
        tick();
        for (int b = 0; b < 2; b++) begin
            d = rand128();
            bus.src_din[DW*g +: DW] = d;
            bus.src_write[g] = 1'b1;
            exp_q.push_back(d);
            tick();
        end
        bus.src_din[DW*g +: DW] = rand128();
        ip_rst = 1'b1;
        #1;
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_src_full", 128'(bus.src_full), 128'(4'hF));
        chk("midrst_out_write", 128'(bus.out_r_write), 128'(0));
        chk("midrst_out_din", bus.out_r_din, 128'(0));
        chk("midrst_grant", 128'(grant_id), 128'(0));
        chk("midrst_pkt_count", 128'(pkt_count), 128'(0));
        chk("midrst_err", 128'(err_bad_write), 128'(0));
        compare_streams("partial_stream");
        tick();
        bus.src_write = '0;
        ip_rst = 1'b0;
        m_rr  = NSRC - 1;
        m_pkt = 0;
        tick();

        // After reset the pointer restarts: source 0 wins with everyone requesting.
        cfg_pkt_len = 16'd1;
        bus.src_req = 4'b1111;
        g = rr_pick(4'b1111);
        chk("post_rst_model", 128'(g), 128'(0));
        do_packet(g, 1, 0, -1, 0, -1, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
